// File: rtl/mips_regfile_sb_if.sv
// mips_regfile_sb_if: writeback, read, issue and scoreboard signals of the register file.
interface mips_regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteAddr;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] ReadAddr1;
  logic [ADDR_W-1:0] ReadAddr2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              IssueValid;
  logic [ADDR_W-1:0] IssueAddr;
  logic              Busy1;
  logic              Busy2;
  logic [ADDR_W:0]   PendCount;
  modport master (
    output RegWrite, WriteAddr, WriteData, ReadAddr1, ReadAddr2, IssueValid, IssueAddr,
    input  ReadData1, ReadData2, Busy1, Busy2, PendCount
  );
  modport slave (
    input  RegWrite, WriteAddr, WriteData, ReadAddr1, ReadAddr2, IssueValid, IssueAddr,
    output ReadData1, ReadData2, Busy1, Busy2, PendCount
  );
endinterface

// File: rtl/mips_regfile_sb.sv
// mips_regfile_sb: MIPS register file with write-to-read bypass and per-register pending bits.
module mips_regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input logic Clk,
  input logic Reset,
  mips_regfile_sb_if.slave rf
);
  localparam int NREGS = 2**ADDR_W;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  pend_q, pend_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              wr, iss, hit1, hit2, inc, dec;
  always_comb begin
    wr   = rf.RegWrite && rf.WriteAddr != '0;
    iss  = rf.IssueValid && rf.IssueAddr != '0;
    hit1 = BYPASS != 0 && wr && rf.WriteAddr == rf.ReadAddr1;
    hit2 = BYPASS != 0 && wr && rf.WriteAddr == rf.ReadAddr2;
    rf.ReadData1 = (Reset || rf.ReadAddr1 == '0) ? '0 : hit1 ? rf.WriteData : regs_q[rf.ReadAddr1];
    rf.ReadData2 = (Reset || rf.ReadAddr2 == '0) ? '0 : hit2 ? rf.WriteData : regs_q[rf.ReadAddr2];
    rf.Busy1 = !Reset && pend_q[rf.ReadAddr1] && !hit1;
    rf.Busy2 = !Reset && pend_q[rf.ReadAddr2] && !hit2;
    rf.PendCount = cnt_q;
    // issue applied after write so a same-address issue keeps the register owned
    pend_d = pend_q;
    if (wr) pend_d[rf.WriteAddr] = 1'b0;
    if (iss) pend_d[rf.IssueAddr] = 1'b1;
    inc   = iss && !pend_q[rf.IssueAddr];
    dec   = wr && pend_q[rf.WriteAddr] && !(iss && rf.IssueAddr == rf.WriteAddr);
    cnt_d = cnt_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr) regs_q[rf.WriteAddr] <= rf.WriteData;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mips_regfile_sb.sv
// tb_mips_regfile_sb: scoreboard bench driving a bypassing and a non-bypassing register file in parallel.
module tb_mips_regfile_sb;
  logic        Clk = 1'b0;
  logic        rst = 1'b1, rw = 1'b0, iv = 1'b0;
  logic [4:0]  wa = '0, a1 = '0, a2 = '0, ia = '0;
  logic [31:0] wd = '0;
  int          checks = 0, errors = 0;
  typedef struct {
    logic [31:0] d1, d2, n1, n2;
    logic        b1, b2, nb1, nb2;
    logic [5:0]  cnt;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] mem [32];
  bit          pend [32];
  always #5 Clk = ~Clk;
  mips_regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) ifb ();
  mips_regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) ifn ();
  assign ifb.RegWrite = rw;   assign ifn.RegWrite = rw;
  assign ifb.WriteAddr = wa;  assign ifn.WriteAddr = wa;
  assign ifb.WriteData = wd;  assign ifn.WriteData = wd;
  assign ifb.ReadAddr1 = a1;  assign ifn.ReadAddr1 = a1;
  assign ifb.ReadAddr2 = a2;  assign ifn.ReadAddr2 = a2;
  assign ifb.IssueValid = iv; assign ifn.IssueValid = iv;
  assign ifb.IssueAddr = ia;  assign ifn.IssueAddr = ia;
  mips_regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_b (.Clk(Clk), .Reset(rst), .rf(ifb.slave));
  mips_regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_n (.Clk(Clk), .Reset(rst), .rf(ifn.slave));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // architectural state advance at a clock edge, using the inputs held during the cycle
  task automatic model_edge();
    if (rst) begin
      foreach (mem[i]) begin mem[i] = '0; pend[i] = 0; end
    end else begin
      if (rw && wa != 0) begin mem[wa] = wd; pend[wa] = 0; end
      if (iv && ia != 0) pend[ia] = 1;
    end
  endtask
  function automatic exp_t expect_now();
    exp_t e;
    int   c = 0;
    bit   f1 = rw && wa != 0 && wa == a1;
    bit   f2 = rw && wa != 0 && wa == a2;
    foreach (pend[i]) c += int'(pend[i]);
    e.cnt = 6'(c);
    e.d1  = rst ? '0 : f1 ? wd : mem[a1];
    e.d2  = rst ? '0 : f2 ? wd : mem[a2];
    e.n1  = rst ? '0 : mem[a1];
    e.n2  = rst ? '0 : mem[a2];
    e.b1  = !rst && pend[a1] && !f1;
    e.b2  = !rst && pend[a2] && !f2;
    e.nb1 = !rst && pend[a1];
    e.nb2 = !rst && pend[a2];
    return e;
  endfunction
  task automatic step(input logic r, input logic w, input logic [4:0] wad, input logic [31:0] wdat,
                      input logic [4:0] r1, input logic [4:0] r2, input logic v, input logic [4:0] iad);
    @(posedge Clk);
    model_edge();
    #1;
    rst = r; rw = w; wa = wad; wd = wdat; a1 = r1; a2 = r2; iv = v; ia = iad;
    sb.push_back(expect_now());
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("b_rd1", ifb.ReadData1, e.d1);
        chk("b_rd2", ifb.ReadData2, e.d2);
        chk("b_busy1", 32'(ifb.Busy1), 32'(e.b1));
        chk("b_busy2", 32'(ifb.Busy2), 32'(e.b2));
        chk("b_cnt", 32'(ifb.PendCount), 32'(e.cnt));
        chk("n_rd1", ifn.ReadData1, e.n1);
        chk("n_rd2", ifn.ReadData2, e.n2);
        chk("n_busy1", 32'(ifn.Busy1), 32'(e.nb1));
        chk("n_busy2", 32'(ifn.Busy2), 32'(e.nb2));
        chk("n_cnt", 32'(ifn.PendCount), 32'(e.cnt));
      end
    end
  end
  initial begin
    foreach (mem[i]) begin mem[i] = '0; pend[i] = 0; end
    @(posedge Clk);
    #1;
    step(1, 1, 5'd3, 32'hFFFF_FFFF, 5'd3, 5'd0, 1, 5'd3);
    for (int i = 0; i < 32; i++) step(0, 0, 0, 0, 5'(i), 5'(31 - i), 0, 0);
    step(0, 1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0, 0, 0);
    step(0, 0, 0, 0, 5'd5, 5'd5, 0, 0);
    step(0, 1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, 1, 5'd0);
    step(0, 0, 0, 0, 5'd0, 5'd5, 0, 0);
    step(0, 0, 0, 0, 5'd7, 5'd7, 1, 5'd7);
    step(0, 1, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd0, 0, 0);
    step(0, 0, 0, 0, 5'd7, 5'd7, 0, 0);
    step(0, 0, 0, 0, 5'd9, 5'd0, 1, 5'd9);
    step(0, 1, 5'd9, 32'h11, 5'd9, 5'd9, 1, 5'd9);
    step(0, 0, 0, 0, 5'd9, 5'd9, 1, 5'd4);
    step(0, 1, 5'd4, 32'h44, 5'd4, 5'd3, 1, 5'd3);
    step(0, 1, 5'd6, 32'h55, 5'd6, 5'd3, 1, 5'd6);
    step(0, 1, 5'd6, 32'h66, 5'd6, 5'd4, 1, 5'd6);
    step(0, 0, 0, 0, 5'd6, 5'd9, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) step(0, 0, 0, 0, 5'(i), 5'(i - 1), 1, 5'(i));
    step(1, 1, 5'd2, 32'hCAFE_F00D, 5'd2, 5'd1, 1, 5'd5);
    step(0, 0, 0, 0, 5'd2, 5'd4, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] m = ($urandom_range(0, 3) == 0) ? 5'h1F : 5'h07;
      step($urandom_range(0, 63) == 0, 1'($urandom), 5'($urandom) & m, $urandom,
           5'($urandom) & m, 5'($urandom) & m, 1'($urandom), 5'($urandom) & m);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge Clk);
    @(negedge Clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_regfile_sb.md
Name: mips_regfile_sb

Overview:
- Next-generation MIPS general-purpose register file for the pipelined datapath.
- Parametrised in data width and register count.
- Clocked writes, two asynchronous read ports with write-to-read bypass, and a hardwired-zero register 0.
- Built-in per-register pending (scoreboard) bits so the decode stage detects RAW hazards against in-flight producers.

Parameters:
DATA_W, 32, register data width in bits
ADDR_W, 5, register address width; register count NREGS = 2**ADDR_W
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return array contents only

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  synchronous, active-high
RegWrite  input  1  writeback enable
WriteAddr  input  ADDR_W  writeback destination
WriteData  input  DATA_W  writeback data
ReadAddr1  input  ADDR_W  read port 1 address
ReadAddr2  input  ADDR_W  read port 2 address
ReadData1  output  DATA_W  read port 1 data (combinational)
ReadData2  output  DATA_W  read port 2 data (combinational)
IssueValid  input  1  instruction with a destination issued this cycle
IssueAddr  input  ADDR_W  destination of the issued instruction
Busy1  output  1  ReadAddr1 has a pending producer
Busy2  output  1  ReadAddr2 has a pending producer
PendCount  output  ADDR_W+1  number of registers currently pending

Behaviour:
- Reset: Reset is synchronous, active-high.
  - On a rising edge with Reset=1, all NREGS registers clear to 0, all pending bits clear, and PendCount clears to 0.
  - Reset has priority over RegWrite and IssueValid in the same cycle.
  - While Reset=1: ReadData1/2 = 0, Busy1/2 = 0.
- Register 0:
  - Always reads 0 and is never pending.
  - Writes to address 0 are discarded; issues to address 0 are ignored (no pending bit, no count change).
- Write: on a rising edge with RegWrite=1 and WriteAddr!=0, reg[WriteAddr] <= WriteData and pending[WriteAddr] is cleared, unless rule "simultaneous" below applies. A write to a non-pending register still updates data.
- Read: ReadDataN = reg[ReadAddrN], combinational, zero latency.
- Bypass (BYPASS=1): if RegWrite=1, WriteAddr==ReadAddrN and WriteAddr!=0, then ReadDataN = WriteData in the same cycle. With BYPASS=0 the new value is visible from the next cycle.
- Busy:
  - BusyN = pending[ReadAddrN], masked to 0 when a bypass hit on that port occurs this cycle.
  - With BYPASS=0, BusyN = pending[ReadAddrN] unmasked.
  - A same-cycle issue does not affect BusyN until the next cycle.
- Issue: on a rising edge with IssueValid=1 and IssueAddr!=0, pending[IssueAddr] <= 1.
- Simultaneous write and issue to the same nonzero address: data is written and the pending bit stays 1, because the new producer owns the register.
- PendCount, updated at the same edge:
  - +1 when a non-pending register becomes pending.
  - −1 when a pending register is cleared by a write.
  - Both events on different registers: net 0.
  - Issue to an already-pending register: +0.
  - Write and issue to the same pending register: +0.
  - Write and issue to the same non-pending register: +1.
  - Never exceeds NREGS−1; no wrap.
- Both read ports may address the same register; each port is evaluated independently.

Test Plan:
- Reset then read: assert Reset one cycle, then read addresses 0..31 -> all ReadData = 0, Busy = 0, PendCount = 0.
- Write/readback: write 0xDEADBEEF to r5 -> ReadData1 = 0xDEADBEEF in the same cycle (bypass) and the following cycle; write 0x12345678 to r0 -> r0 still reads 0.
- Scoreboard: issue r7; next cycle Busy1 = 1 (ReadAddr1 = 7) and PendCount = 1. Write r7 = 0xA5A5A5A5 -> same cycle Busy1 = 0, ReadData1 = 0xA5A5A5A5; next cycle PendCount = 0.
- Simultaneous: with r9 pending, write r9 = 0x11 and issue r9 in the same cycle -> next cycle data = 0x11, Busy = 1, PendCount unchanged (1). Issue r3 while writing pending r4 -> count stays the same.
- Reset mid-operation: pend r1..r4 (PendCount = 4), then assert Reset with RegWrite = 1 to r2 -> next cycle all registers 0, PendCount = 0, r2 = 0.
- BYPASS=0 build: write r6 = 0x55 -> same-cycle ReadData = old value and Busy reflects the pending bit; next cycle ReadData = 0x55.
